// File: rtl/hc4053_scan_sequencer.sv
// hc4053_scan_sequencer: drives the enable and select lines of a 74HC4053
// triple 2:1 analog switch. It steps through the select codes with
// break-before-make and a settle delay. After each settle it issues a
// sample request to the ADC capture stage and waits for its acknowledge.
// Optional build macro: ACK_TIMEOUT_EN. When it is defined, an
// unacknowledged request times out, advances the scan and sets a sticky
// timeout_err flag.
module hc4053_scan_sequencer #(
  parameter int NUM_CODES      = 8,
  parameter int BBM_CYCLES     = 2,
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       cont,
  input  logic       abort,
  input  logic       sample_ack,
  output logic       mux_e_n,
  output logic [2:0] mux_s,
  output logic       sample_req,
  output logic [2:0] code_out,
  output logic       busy,
  output logic       done,
  output logic       timeout_err
);

  // One shared phase counter. It is sized for the longest phase.
  localparam int MAX_A   = (BBM_CYCLES > SETTLE_CYCLES) ? BBM_CYCLES : SETTLE_CYCLES;
  localparam int MAX_CNT = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] BBM_LAST    = CW'(BBM_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [2:0]    LAST_CODE   = 3'(NUM_CODES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BREAK  = 2'd1,
    SETTLE = 2'd2,
    SAMPLE = 2'd3
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic          mux_e_n_r, mux_e_n_nxt_s;
  logic [2:0]    mux_s_r, mux_s_nxt_s;
  logic          req_r, req_nxt_s;
  logic          busy_r;
  logic          done_r, done_nxt_s;
  logic          advance_s;
  logic          terr_r, terr_nxt_s;
`ifdef ACK_TIMEOUT_EN
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic          timeout_s;
`endif

  // Next-state and next-output decode. Abort overrides every state.
  always_comb begin
    state_nxt_s   = state_r;
    cnt_nxt_s     = {CW{1'b0}};
    mux_e_n_nxt_s = mux_e_n_r;
    mux_s_nxt_s   = mux_s_r;
    req_nxt_s     = req_r;
    done_nxt_s    = 1'b0;
    terr_nxt_s    = terr_r;
    advance_s     = 1'b0;
`ifdef ACK_TIMEOUT_EN
    timeout_s     = 1'b0;
`endif
    if (abort) begin
      state_nxt_s   = IDLE;
      mux_e_n_nxt_s = 1'b1;
      req_nxt_s     = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            state_nxt_s   = BREAK;
            mux_s_nxt_s   = 3'd0;
            mux_e_n_nxt_s = 1'b1;
`ifdef ACK_TIMEOUT_EN
            terr_nxt_s    = 1'b0;
`endif
          end else begin
            mux_e_n_nxt_s = 1'b1;
          end
        end
        BREAK: begin
          if (cnt_r == BBM_LAST) begin
            state_nxt_s   = SETTLE;
            mux_e_n_nxt_s = 1'b0;
          end else begin
            cnt_nxt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        SETTLE: begin
          if (cnt_r == SETTLE_LAST) begin
            state_nxt_s = SAMPLE;
            req_nxt_s   = 1'b1;
          end else begin
            cnt_nxt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
        end
        SAMPLE: begin
`ifdef ACK_TIMEOUT_EN
          timeout_s = !sample_ack && (cnt_r == TIMEOUT_LAST);
          advance_s = sample_ack || timeout_s;
          if (timeout_s) begin
            terr_nxt_s = 1'b1;
          end else begin
            cnt_nxt_s = cnt_r + {{(CW-1){1'b0}}, 1'b1};
          end
`else
          advance_s = sample_ack;
`endif
          if (advance_s) begin
            req_nxt_s     = 1'b0;
            mux_e_n_nxt_s = 1'b1;
            cnt_nxt_s     = {CW{1'b0}};
            if (mux_s_r < LAST_CODE) begin
              mux_s_nxt_s = mux_s_r + 3'd1;
              state_nxt_s = BREAK;
            end else if (cont) begin
              mux_s_nxt_s = 3'd0;
              state_nxt_s = BREAK;
            end else begin
              state_nxt_s = IDLE;
              done_nxt_s  = 1'b1;
            end
          end else begin
            req_nxt_s = 1'b1;
          end
        end
        default: begin
          state_nxt_s   = IDLE;
          mux_e_n_nxt_s = 1'b1;
          req_nxt_s     = 1'b0;
        end
      endcase
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= {CW{1'b0}};
      mux_e_n_r <= 1'b1;
      mux_s_r   <= 3'd0;
      req_r     <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      terr_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      cnt_r     <= cnt_nxt_s;
      mux_e_n_r <= mux_e_n_nxt_s;
      mux_s_r   <= mux_s_nxt_s;
      req_r     <= req_nxt_s;
      busy_r    <= (state_nxt_s != IDLE);
      done_r    <= done_nxt_s;
      terr_r    <= terr_nxt_s;
    end
  end

  assign mux_e_n    = mux_e_n_r;
  assign mux_s      = mux_s_r;
  assign code_out   = mux_s_r;
  assign sample_req = req_r;
  assign busy       = busy_r;
  assign done       = done_r;
`ifdef ACK_TIMEOUT_EN
  assign timeout_err = terr_r;
`else
  assign timeout_err = 1'b0;
`endif

endmodule

// File: doc/hc4053_scan_sequencer.md
Name: hc4053_scan_sequencer

Overview:
Control stage directly upstream of the 74HC4053 triple 2:1 analog switch model. Drives the switch's active-low enable and 3-bit select, stepping through select codes with break-before-make and a settle delay. After each settle it issues a sample request to the downstream ADC capture and waits for acknowledge. Supports single-pass and continuous scanning, plus synchronous abort.

Parameters:
NUM_CODES, 8, select codes per pass, scanned 0..NUM_CODES-1; legal range 1..8
BBM_CYCLES, 2, cycles mux_e_n held high around each select change; minimum 1
SETTLE_CYCLES, 16, cycles enabled before sample_req rises; minimum 1
TIMEOUT_CYCLES, 256, ack timeout limit; used only with ACK_TIMEOUT_EN

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  begin a pass; sampled only in IDLE
cont  in  1  continuous mode; sampled at end of each pass
abort  in  1  synchronous abort; wins over every other input
sample_ack  in  1  ADC capture done; meaningful only while sample_req=1
mux_e_n  out  1  to switch E, active low
mux_s  out  3  to switch S[2:0]
sample_req  out  1  sample request, level
code_out  out  3  code belonging to the current request, equal to mux_s
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at end of a non-continuous pass
timeout_err  out  1  sticky error flag; only with ACK_TIMEOUT_EN, otherwise tied 0

Behaviour:
- Reset (async assert, sync release): state IDLE, mux_e_n=1, mux_s=0, sample_req=0, code_out=0, busy=0, done=0, timeout_err=0, counters=0.
- States: IDLE, BREAK, SETTLE, SAMPLE.
- IDLE: mux_e_n=1. On the edge where start=1, load mux_s=0 and enter BREAK. start is ignored in every other state.
- BREAK: mux_e_n=1 for exactly BBM_CYCLES cycles. mux_s never changes while mux_e_n=0. Then drive mux_e_n=0 and enter SETTLE.
- SETTLE: count SETTLE_CYCLES cycles, then sample_req=1 and enter SAMPLE.
- Latency: start sampled at edge k gives mux_e_n falling at edge k+BBM_CYCLES and sample_req rising at edge k+BBM_CYCLES+SETTLE_CYCLES.
- SAMPLE: sample_req stays high until sample_ack=1 is sampled. At that edge:
  - sample_req falls and mux_e_n rises.
  - If mux_s < NUM_CODES-1: mux_s increments and state goes to BREAK.
  - Else, if cont=1: mux_s wraps to 0 and state goes to BREAK.
  - Else: state goes to IDLE, mux_s is held, and done pulses on the following cycle.
- sample_ack while sample_req=0 is ignored. A held ack is honoured once per request only, because req drops on the same edge.
- abort=1 at any edge, any state: next state IDLE, mux_e_n=1, sample_req=0, no done pulse, mux_s held. abort together with start in IDLE stays in IDLE.
- NUM_CODES=1: every pass samples code 0 only. In cont mode, each wrap still passes through BREAK.
- Counters are wide enough for their parameter, and each resets to 0 on state entry.

Optional Feature:
ACK_TIMEOUT_EN
- Defined: in SAMPLE, count cycles with sample_ack=0. Reaching TIMEOUT_CYCLES sets timeout_err=1, drops sample_req and advances exactly as if ack had arrived.
  - timeout_err clears only on rst or on the next accepted start.
- Undefined: no timeout counter. SAMPLE waits for ack indefinitely and timeout_err is constant 0.

Test Plan:
- BBM=2, SETTLE=4, NUM_CODES=8, cont=0: start pulse at edge 0, ack 1 cycle after each req -> mux_e_n low at edge 2, req high at edge 6; mux_s steps 0..7; mux_e_n is 1 on every edge where mux_s changes; one done pulse; then IDLE with mux_s=7.
- cont=1, NUM_CODES=3 -> codes 0,1,2,0,1,2... with no done pulse. Drop cont during code 2, then ack -> IDLE with one done pulse.
- Assert abort during SETTLE of code 4 -> next cycle mux_e_n=1, sample_req=0, busy=0, no done, mux_s=4. A new start then restarts at code 0.
- Hold sample_ack=1 continuously -> each code's req lasts exactly 1 cycle; no code is skipped; 8 requests per pass.
- Assert rst mid-SAMPLE at a non-edge time -> outputs go to reset values immediately; start in the same cycle as rst is ignored.
- ACK_TIMEOUT_EN with TIMEOUT_CYCLES=10, no ack -> req falls 10 cycles after rising, timeout_err=1, next code proceeds; next start clears timeout_err.
